axi_lite_regfile: RTL

Parametrised AXI4-Lite slave register file; successor to the fixed 4-bit-address, 32-bit bus bundle. It generalises register count and data width and adds behaviour the bare bundle lacks:
- independent AW/W acceptance
- WSTRB byte-lane writes
- per-register read-only masking
- SLVERR on out-of-range addresses
- per-register write strobes toward user logic

It sits behind the team's AXI-Lite TB/DUT interface as the standard control/status register bank.

---
 rtl/axi_lite_regfile.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/axi_lite_regfile.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : axi_lite_regfile
// Description : Parametrised AXI4-Lite slave register bank with byte strobes,
//               read-only masking, SLVERR decode and per-register write pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_lite_regfile #(
    parameter int                             DATA_WIDTH = 32,
    parameter int                             NUM_REGS   = 8,
    parameter int                             ADDR_WIDTH = 6,
    parameter logic [NUM_REGS-1:0]            RO_MASK    = '0,
    parameter logic [NUM_REGS*DATA_WIDTH-1:0] RESET_VAL  = '0
) (
    input  logic                           ACLK,
    input  logic                           ARESET,
    input  logic [ADDR_WIDTH-1:0]          AWADDR,
    input  logic                           AWVALID,
    output logic                           AWREADY,
    input  logic [DATA_WIDTH-1:0]          WDATA,
    input  logic [DATA_WIDTH/8-1:0]        WSTRB,
    input  logic                           WVALID,
    output logic                           WREADY,
    output logic                           BVALID,
    output logic [1:0]                     BRESP,
    input  logic                           BREADY,
    input  logic [ADDR_WIDTH-1:0]          ARADDR,
    input  logic                           ARVALID,
    output logic                           ARREADY,
    output logic [DATA_WIDTH-1:0]          RDATA,
    output logic                           RVALID,
    output logic [1:0]                     RRESP,
    input  logic                           RREADY,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
    output logic [NUM_REGS-1:0]            wr_pulse
);

    localparam int         c_nbytes = DATA_WIDTH / 8;
    localparam int         c_lsb    = $clog2(c_nbytes);
    localparam int         c_iw     = ADDR_WIDTH - c_lsb;
    localparam logic [1:0] c_okay   = 2'b00;
    localparam logic [1:0] c_slverr = 2'b10;

    localparam logic [1:0] W_IDLE   = 2'd0;
    localparam logic [1:0] W_HAVE_A = 2'd1;
    localparam logic [1:0] W_HAVE_W = 2'd2;
    localparam logic [1:0] W_RESP   = 2'd3;
    localparam logic [0:0] R_IDLE   = 1'b0;
    localparam logic [0:0] R_DATA   = 1'b1;

    logic [1:0]                           r_wstate, w_wstate_nxt;
    logic [0:0]                           r_rstate, w_rstate_nxt;
    logic [ADDR_WIDTH-1:0]                r_awaddr;
    logic [DATA_WIDTH-1:0]                r_wdata;
    logic [c_nbytes-1:0]                  r_wstrb;
    logic                                 w_aw_hs, w_w_hs, w_ar_hs, w_commit;
    logic [ADDR_WIDTH-1:0]                w_addr;
    logic [DATA_WIDTH-1:0]                w_data;
    logic [c_nbytes-1:0]                  w_strb;
    logic [c_iw-1:0]                      w_widx, w_ridx;
    logic                                 w_win, w_rin;
    logic [NUM_REGS-1:0]                  w_we, r_pulse;
    logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  r_regs;
    logic [DATA_WIDTH-1:0]                w_rdata, r_rdata;
    logic [1:0]                           r_bresp, r_rresp;

    // ---------------- write channel FSM ----------------
    always_ff @(posedge ACLK) begin
        if (ARESET) r_wstate <= W_IDLE;
        else        r_wstate <= w_wstate_nxt;
    end

    always_comb begin
        w_wstate_nxt = r_wstate;
        case (r_wstate)
            W_IDLE: begin
                if (w_commit)     w_wstate_nxt = W_RESP;
                else if (w_aw_hs) w_wstate_nxt = W_HAVE_A;
                else if (w_w_hs)  w_wstate_nxt = W_HAVE_W;
            end
            W_HAVE_A, W_HAVE_W: if (w_commit) w_wstate_nxt = W_RESP;
            W_RESP:             if (BREADY)   w_wstate_nxt = W_IDLE;
            default:            w_wstate_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        AWREADY = 1'b0;
        WREADY  = 1'b0;
        if (!ARESET) begin
            AWREADY = (r_wstate == W_IDLE) || (r_wstate == W_HAVE_W);
            WREADY  = (r_wstate == W_IDLE) || (r_wstate == W_HAVE_A);
        end
        BVALID = (r_wstate == W_RESP);
    end

    assign w_aw_hs  = AWVALID && AWREADY;
    assign w_w_hs   = WVALID && WREADY;
    // Completion needs an address (now or latched) and data (now or latched).
    assign w_commit = (w_aw_hs || (r_wstate == W_HAVE_A)) && (w_w_hs || (r_wstate == W_HAVE_W));
    assign w_addr   = (r_wstate == W_HAVE_A) ? r_awaddr : AWADDR;
    assign w_data   = (r_wstate == W_HAVE_W) ? r_wdata  : WDATA;
    assign w_strb   = (r_wstate == W_HAVE_W) ? r_wstrb  : WSTRB;
    assign w_widx   = c_iw'(w_addr >> c_lsb);
    assign w_win    = int'(w_widx) < NUM_REGS;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_awaddr <= '0;
            r_wdata  <= '0;
            r_wstrb  <= '0;
            r_bresp  <= c_okay;
            r_pulse  <= '0;
        end else begin
            if (w_aw_hs && (r_wstate == W_IDLE)) r_awaddr <= AWADDR;
            if (w_w_hs  && (r_wstate == W_IDLE)) begin
                r_wdata <= WDATA;
                r_wstrb <= WSTRB;
            end
            if (w_commit) r_bresp <= w_win ? c_okay : c_slverr;
            r_pulse <= (|w_strb) ? w_we : '0;
        end
    end

    always_comb begin
        w_we = '0;
        for (int i = 0; i < NUM_REGS; i++)
            w_we[i] = w_commit && w_win && (w_widx == c_iw'(i)) && !RO_MASK[i];
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            for (int i = 0; i < NUM_REGS; i++)
                r_regs[i] <= RESET_VAL[i*DATA_WIDTH +: DATA_WIDTH];
        end else begin
            for (int i = 0; i < NUM_REGS; i++)
                for (int b = 0; b < c_nbytes; b++)
                    if (w_we[i] && w_strb[b])
                        r_regs[i][b*8 +: 8] <= w_data[b*8 +: 8];
        end
    end

    // ---------------- read channel FSM ----------------
    always_ff @(posedge ACLK) begin
        if (ARESET) r_rstate <= R_IDLE;
        else        r_rstate <= w_rstate_nxt;
    end

    always_comb begin
        w_rstate_nxt = r_rstate;
        case (r_rstate)
            R_IDLE:  if (w_ar_hs) w_rstate_nxt = R_DATA;
            R_DATA:  if (RREADY)  w_rstate_nxt = R_IDLE;
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    always_comb begin
        ARREADY = !ARESET && (r_rstate == R_IDLE);
        RVALID  = (r_rstate == R_DATA);
    end

    assign w_ar_hs = ARVALID && ARREADY;
    assign w_ridx  = c_iw'(ARADDR >> c_lsb);
    assign w_rin   = int'(w_ridx) < NUM_REGS;

    // Reads sample the pre-edge register image, so a same-edge write is not visible.
    always_comb begin
        w_rdata = '0;
        for (int i = 0; i < NUM_REGS; i++)
            if (w_ridx == c_iw'(i)) w_rdata = r_regs[i];
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_rdata <= '0;
            r_rresp <= c_okay;
        end else if (w_ar_hs) begin
            r_rdata <= w_rin ? w_rdata : '0;
            r_rresp <= w_rin ? c_okay : c_slverr;
        end
    end

    assign BRESP    = r_bresp;
    assign RDATA    = r_rdata;
    assign RRESP    = r_rresp;
    assign reg_out  = r_regs;
    assign wr_pulse = r_pulse;

endmodule
`default_nettype wire
